// File: rtl/nano_dsi_rx_data.sv
// D-PHY data lane receiver: LP start-of-transmission detection, HS sync hunt
// and LSB-first byte deserialization with end-of-transmission and error strobes.
module nano_dsi_rx_data #(
    parameter logic [7:0] SYNC_PATTERN = 8'hB8,
    parameter int         SYNC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_lp_p,
    input  logic       data_lp_n,
    input  logic       data_hs,
    input  logic [7:0] cfg_hs_settle,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sot,
    output logic       rx_eot,
    output logic       rx_err,
    output logic       rx_active
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_WAIT11,
        ST_IDLE,
        ST_LP01,
        ST_SETTLE,
        ST_SYNC,
        ST_DATA
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    lp_meta, lp;
    logic          hs_s;
    logic [7:0]    timer, timer_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [7:0]    sr, sr_nx, sr_shift;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    data_nx;
    logic          valid_nx, sot_nx, eot_nx, err_nx, active_nx;

    // LP lines are asynchronous and need two flops; HS is already clk-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_meta <= 2'b00;
            lp      <= 2'b00;
            hs_s    <= 1'b0;
        end else begin
            lp_meta <= {data_lp_p, data_lp_n};
            lp      <= lp_meta;
            hs_s    <= data_hs;
        end
    end

    assign sr_shift = {hs_s, sr[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT11;
            timer     <= 8'd0;
            tmo       <= '0;
            sr        <= 8'd0;
            bit_cnt   <= 3'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_sot    <= 1'b0;
            rx_eot    <= 1'b0;
            rx_err    <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            tmo       <= tmo_nx;
            sr        <= sr_nx;
            bit_cnt   <= bit_cnt_nx;
            rx_data   <= data_nx;
            rx_valid  <= valid_nx;
            rx_sot    <= sot_nx;
            rx_eot    <= eot_nx;
            rx_err    <= err_nx;
            rx_active <= active_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        tmo_nx     = tmo;
        sr_nx      = sr;
        bit_cnt_nx = bit_cnt;
        data_nx    = rx_data;
        valid_nx   = 1'b0;
        sot_nx     = 1'b0;
        eot_nx     = 1'b0;
        err_nx     = 1'b0;
        active_nx  = rx_active;

        case (state)
            ST_WAIT11: begin
                if (lp == 2'b11) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (lp == 2'b01) begin
                    state_nx = ST_LP01;
                end else if (lp != 2'b11) begin
                    err_nx   = 1'b1;
                    state_nx = ST_WAIT11;
                end
            end
            ST_LP01: begin
                if (lp == 2'b00) begin
                    state_nx = ST_SETTLE;
                    timer_nx = cfg_hs_settle;
                end else if (lp == 2'b11) begin
                    state_nx = ST_IDLE;
                end else if (lp == 2'b10) begin
                    err_nx   = 1'b1;
                    state_nx = ST_WAIT11;
                end
            end
            ST_SETTLE, ST_SYNC, ST_DATA: begin
                if (lp != 2'b00) begin
                    // A byte completing on the exit cycle is still delivered.
                    eot_nx    = 1'b1;
                    active_nx = 1'b0;
                    if (lp == 2'b11) begin
                        state_nx = ST_IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ST_WAIT11;
                    end
                    if (state == ST_DATA && bit_cnt == 3'd7) begin
                        data_nx  = sr_shift;
                        valid_nx = 1'b1;
                    end
                end else if (state == ST_SETTLE) begin
                    if (timer <= 8'd1) begin
                        state_nx = ST_SYNC;
                        sr_nx    = 8'd0;
                        tmo_nx   = TW'(SYNC_TIMEOUT);
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
                end else if (state == ST_SYNC) begin
                    sr_nx = sr_shift;
                    if (sr_shift == SYNC_PATTERN) begin
                        sot_nx     = 1'b1;
                        active_nx  = 1'b1;
                        bit_cnt_nx = 3'd0;
                        state_nx   = ST_DATA;
                    end else if (tmo <= TW'(1)) begin
                        err_nx   = 1'b1;
                        state_nx = ST_WAIT11;
                    end else begin
                        tmo_nx = tmo - TW'(1);
                    end
                end else begin
                    sr_nx      = sr_shift;
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        data_nx  = sr_shift;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: state_nx = ST_WAIT11;
        endcase
    end

endmodule
